// File: rtl/playfield_line_clear_pkg.sv
// Shared types and sizes for the locked-tile playfield and its line-clear pass.
package playfield_line_clear_pkg;

    localparam int PLAYFIELD_ROWS    = 20;
    localparam int PLAYFIELD_COLS    = 10;
    localparam int LOCK_TILES        = 4;
    localparam int MAX_LINES_CLEARED = 4;

    typedef enum logic [3:0] {
        BLANK   = 4'd0,
        GHOST   = 4'd1,
        GARBAGE = 4'd2,
        TILE_I  = 4'd3,
        TILE_O  = 4'd4,
        TILE_T  = 4'd5,
        TILE_S  = 4'd6,
        TILE_Z  = 4'd7,
        TILE_J  = 4'd8,
        TILE_L  = 4'd9
    } tile_type_t;

    typedef logic [4:0] row_idx_t;
    typedef logic [3:0] col_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_COMPACT,
        ST_FILL,
        ST_DONE
    } state_t;

    // GHOST is a display-only overlay, so it never counts as an occupied cell.
    function automatic logic is_solid(tile_type_t t);
        return (t != BLANK) && (t != GHOST);
    endfunction

endpackage

// File: rtl/playfield_line_clear_if.sv
// Lock request handshake and pass status between the game controller and the playfield.
interface playfield_line_clear_if;
    import playfield_line_clear_pkg::*;

    logic                            clear_all;
    logic                            lock_valid;
    logic                            lock_ready;
    tile_type_t                      lock_type;
    row_idx_t [LOCK_TILES-1:0]       lock_row;
    col_idx_t [LOCK_TILES-1:0]       lock_col;
    logic                            busy;
    logic                            done;
    logic [2:0]                      lines_cleared;
    logic                            lock_overlap;

    modport master (
        output clear_all, lock_valid, lock_type, lock_row, lock_col,
        input  lock_ready, busy, done, lines_cleared, lock_overlap
    );

    modport slave (
        input  clear_all, lock_valid, lock_type, lock_row, lock_col,
        output lock_ready, busy, done, lines_cleared, lock_overlap
    );

endinterface

// File: rtl/playfield_line_clear_row_full.sv
// Combinational full-row detector; also used by the ghost and top-out logic.
module playfield_row_full
    import playfield_line_clear_pkg::*;
#(
    parameter int COLS = PLAYFIELD_COLS
) (
    input  tile_type_t row [COLS],
    output logic       full
);

    always_comb begin
        full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (!is_solid(row[c])) full = 1'b0;
        end
    end

endmodule

// File: rtl/playfield_line_clear.sv
// Playfield register: writes a locked piece, then compacts full rows out bottom-up
// and back-fills blank rows at the top, reporting how many lines were removed.
module playfield_line_clear
    import playfield_line_clear_pkg::*;
#(
    parameter int ROWS = PLAYFIELD_ROWS,
    parameter int COLS = PLAYFIELD_COLS
) (
    input  logic                  clk,
    input  logic                  rst_l,
    playfield_line_clear_if.slave bus,
    output tile_type_t            tile_type [ROWS][COLS]
);

    state_t                    state_q, state_d;
    row_idx_t                  src_q, src_d;
    row_idx_t                  dst_q, dst_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [2:0]                lines_q, lines_d;
    tile_type_t                type_q, type_d;
    row_idx_t [LOCK_TILES-1:0] row_q, row_d;
    col_idx_t [LOCK_TILES-1:0] col_q, col_d;
    tile_type_t                field_q [ROWS][COLS];
    tile_type_t                field_d [ROWS][COLS];
    logic                      ready_q, ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      overlap_q, overlap_d;

    tile_type_t                src_row [COLS];
    logic                      src_full;

    function automatic logic in_range(row_idx_t r, col_idx_t c);
        return (int'(r) < ROWS) && (int'(c) < COLS);
    endfunction

    always_comb begin
        for (int c = 0; c < COLS; c++) src_row[c] = field_q[src_q][c];
    end

    playfield_row_full #(.COLS(COLS)) u_row_full (
        .row  (src_row),
        .full (src_full)
    );

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        lines_d   = lines_q;
        type_d    = type_q;
        row_d     = row_q;
        col_d     = col_q;
        field_d   = field_q;
        overlap_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.lock_valid && ready_q) begin
                    type_d  = bus.lock_type;
                    row_d   = bus.lock_row;
                    col_d   = bus.lock_col;
                    state_d = ST_WRITE;
                    // The field cannot change before WRITE, so the overlap is judged now and shown there.
                    for (int t = 0; t < LOCK_TILES; t++) begin
                        if (in_range(bus.lock_row[t], bus.lock_col[t]) &&
                            field_q[bus.lock_row[t]][bus.lock_col[t]] != BLANK)
                            overlap_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (is_solid(type_q)) begin
                    for (int t = 0; t < LOCK_TILES; t++) begin
                        if (in_range(row_q[t], col_q[t])) field_d[row_q[t]][col_q[t]] = type_q;
                    end
                end
                src_d   = row_idx_t'(ROWS - 1);
                dst_d   = row_idx_t'(ROWS - 1);
                cnt_d   = 3'd0;
                state_d = ST_COMPACT;
            end
            ST_COMPACT: begin
                if (src_full) begin
                    if (cnt_q < 3'(MAX_LINES_CLEARED)) cnt_d = cnt_q + 3'd1;
                end else begin
                    for (int c = 0; c < COLS; c++) field_d[dst_q][c] = field_q[src_q][c];
                    if (dst_q != '0) dst_d = dst_q - row_idx_t'(1);
                end
                if (src_q == '0) begin
                    state_d = (cnt_d != 3'd0) ? ST_FILL : ST_DONE;
                end else begin
                    src_d = src_q - row_idx_t'(1);
                end
            end
            ST_FILL: begin
                for (int c = 0; c < COLS; c++) field_d[dst_q][c] = BLANK;
                if (dst_q == '0) state_d = ST_DONE;
                else             dst_d   = dst_q - row_idx_t'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_DONE) lines_d = cnt_d;

        // A new-game wipe wins over everything, including a lock request in the same cycle.
        if (bus.clear_all) begin
            state_d   = ST_IDLE;
            lines_d   = 3'd0;
            overlap_d = 1'b0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) field_d[r][c] = BLANK;
        end
    end

    assign ready_d = (state_d == ST_IDLE);
    assign busy_d  = (state_d != ST_IDLE);
    assign done_d  = (state_d == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            lines_q   <= '0;
            type_q    <= BLANK;
            row_q     <= '0;
            col_q     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overlap_q <= 1'b0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) field_q[r][c] <= BLANK;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            lines_q   <= lines_d;
            type_q    <= type_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overlap_q <= overlap_d;
            field_q   <= field_d;
        end
    end

    assign tile_type         = field_q;
    assign bus.lock_ready    = ready_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.lines_cleared = lines_q;
    assign bus.lock_overlap  = overlap_q;

endmodule
